uart_wb_csr: RTL and testbench

Wishbone slave register block that sits directly downstream of the UART receiver.
- Drains bytes from the receiver's RX FIFO into the bus, one byte per read.
- Exposes receiver status and latches the receiver's irq and frame-error pulses into sticky bits.
- Owns the clk_div baud register that drives the receiver.
- Produces one level-sensitive interrupt to the CPU.

---
 rtl/uart_csr_pkg.sv | 24 ++
 rtl/uart_wb_csr.sv | 129 ++++++++++++
 tb/tb_uart_wb_csr.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_csr_pkg.sv
// Shared constants for the UART receive-side Wishbone CSR block:
// register offsets, STAT/CTRL bit positions and the bus FSM encoding.
package uart_csr_pkg;

    localparam logic [3:0] RX_DATA_OFF = 4'h0;
    localparam logic [3:0] STAT_OFF    = 4'h4;
    localparam logic [3:0] CTRL_OFF    = 4'h8;
    localparam logic [3:0] CLK_DIV_OFF = 4'hC;

    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_FERR  = 3;
    localparam int STAT_IRQ   = 4;

    localparam int CTRL_IRQ_EN   = 0;
    localparam int RX_EMPTY_FLAG = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } csr_state_e;

endpackage

// File: rtl/uart_wb_csr.sv
// Wishbone slave CSR block for the UART receiver: drains the RX FIFO, holds
// sticky irq/frame-error status, owns the baud divisor and drives the CPU irq.
module uart_wb_csr
    import uart_csr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter logic [31:0] DEFAULT_CLK_DIV = 32'd434,
    parameter logic [31:0] MIN_CLK_DIV     = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [7:0]  rx_data,
    input  logic        rx_empty,
    input  logic        rx_full,
    input  logic        rx_busy,
    input  logic        rx_irq,
    input  logic        rx_frame_err,
    output logic        rx_pop,
    output logic [31:0] clk_div,
    output logic        irq_o
);

    csr_state_e  state;
    logic        irq_en;
    logic        irq_pending;
    logic        frame_err_sticky;
    logic        hit;
    logic        accept;
    logic        wr;
    logic [3:0]  off;
    logic [31:0] rd_val;
    logic [31:0] div_merged;
    logic        stat_clr;
    logic        unused_ok;

    assign hit    = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign accept = hit & (state == IDLE);
    assign wr     = accept & wbs_we_i;
    assign off    = {wbs_adr_i[3:2], 2'b00};
    // Byte offset within a word carries no meaning for 32-bit registers.
    assign unused_ok = ^wbs_adr_i[1:0];

    assign stat_clr = wr & (off == STAT_OFF) & wbs_sel_i[0];

    always_comb begin
        rd_val = 32'h0;
        case (off)
            RX_DATA_OFF: begin
                rd_val[RX_EMPTY_FLAG] = rx_empty;
                rd_val[7:0]           = rx_empty ? 8'h00 : rx_data;
            end
            STAT_OFF: begin
                rd_val[STAT_EMPTY] = rx_empty;
                rd_val[STAT_FULL]  = rx_full;
                rd_val[STAT_BUSY]  = rx_busy;
                rd_val[STAT_FERR]  = frame_err_sticky;
                rd_val[STAT_IRQ]   = irq_pending;
            end
            CTRL_OFF:    rd_val[CTRL_IRQ_EN] = irq_en;
            CLK_DIV_OFF: rd_val = clk_div;
            default:     rd_val = 32'h0;
        endcase
    end

    always_comb begin
        div_merged = clk_div;
        for (int i = 0; i < 4; i++)
            if (wbs_sel_i[i]) div_merged[8*i +: 8] = wbs_dat_i[8*i +: 8];
    end

    // Bus FSM: side effects on the accepting edge, ack/pop in the single RESP cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            rx_pop    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= 32'h0;
                    rx_pop    <= 1'b0;
                    if (hit) begin
                        state     <= RESP;
                        wbs_ack_o <= 1'b1;
                        wbs_dat_o <= wbs_we_i ? 32'h0 : rd_val;
                        rx_pop    <= ~wbs_we_i & (off == RX_DATA_OFF) & ~rx_empty;
                    end
                end
                default: begin
                    state     <= IDLE;
                    wbs_ack_o <= 1'b0;
                    wbs_dat_o <= 32'h0;
                    rx_pop    <= 1'b0;
                end
            endcase
        end
    end

    // Sticky status: a same-cycle set overrides a W1C clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_div          <= DEFAULT_CLK_DIV;
            irq_en           <= 1'b0;
            irq_pending      <= 1'b0;
            frame_err_sticky <= 1'b0;
            irq_o            <= 1'b0;
        end else begin
            irq_pending      <= rx_irq | (irq_pending & ~(stat_clr & wbs_dat_i[STAT_IRQ]));
            frame_err_sticky <= rx_frame_err |
                                (frame_err_sticky & ~(stat_clr & wbs_dat_i[STAT_FERR]));
            irq_o            <= irq_pending & irq_en;
            if (wr && off == CTRL_OFF && wbs_sel_i[0])
                irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            if (wr && off == CLK_DIV_OFF)
                clk_div <= (div_merged < MIN_CLK_DIV) ? MIN_CLK_DIV : div_merged;
        end
    end

endmodule

// File: tb/tb_uart_wb_csr.sv
// Bench for uart_wb_csr: register vector table, hand sequences for FIFO
// draining, sticky bits and reset, then random traffic against a register model.
module tb_uart_wb_csr;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc, stb, we_i;
    logic [3:0]  sel_i;
    logic [31:0] adr_i, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic [7:0]  rx_data;
    logic        rx_empty, rx_full, rx_busy, rx_irq, rx_frame_err;
    logic        rx_pop;
    logic [31:0] clk_div;
    logic        irq_o;

    uart_wb_csr dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we_i), .wbs_sel_i(sel_i),
        .wbs_adr_i(adr_i), .wbs_dat_i(dat_i), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .rx_data(rx_data), .rx_empty(rx_empty), .rx_full(rx_full), .rx_busy(rx_busy),
        .rx_irq(rx_irq), .rx_frame_err(rx_frame_err), .rx_pop(rx_pop),
        .clk_div(clk_div), .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model of the register file and the receiver FIFO contents.
    logic [31:0] m_div;
    bit          m_en, m_pend, m_ferr;
    logic [7:0]  q[$];

    typedef struct {
        bit          we;
        logic [3:0]  off;
        logic [3:0]  sel;
        logic [31:0] dat;
        bit          chk_rd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic set_fifo();
        rx_empty = (q.size() == 0);
        rx_data  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic model_reset();
        m_div = 32'd434; m_en = 0; m_pend = 0; m_ferr = 0;
    endtask

    task automatic pulse(input bit irq, input bit ferr);
        @(posedge clk); #1;
        rx_irq = irq; rx_frame_err = ferr;
        @(posedge clk); #1;
        rx_irq = 0; rx_frame_err = 0;
        if (irq)  m_pend = 1;
        if (ferr) m_ferr = 1;
    endtask

    task automatic bus(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                       input logic [31:0] dat, input bit irq_same,
                       output logic [31:0] rdata, output int pops, output bit pop_in_ack);
        bit got;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we_i = we; adr_i = adr; sel_i = sel; dat_i = dat;
        if (irq_same) rx_irq = 1;
        got = 0; pops = 0; pop_in_ack = 0; rdata = 32'h0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk); #1;
            rx_irq = 0;
            if (rx_pop) pops++;
            if (ack) begin
                got = 1; rdata = dat_o; pop_in_ack = rx_pop;
            end
        end
        cyc = 0; stb = 0; we_i = 0;
        if (!got) chk("ack_timeout", 32'd0, 32'd1);
        if (pop_in_ack && q.size() != 0) begin
            q.delete(0);
            set_fifo();
        end
        @(posedge clk); #1;
        if (rx_pop) pops++;
    endtask

    task automatic xact(input string nm, input bit we, input logic [3:0] off,
                        input logic [3:0] sel, input logic [31:0] dat, input bit irq_same,
                        output logic [31:0] rd);
        logic [31:0] exp_rd, mg;
        bit          exp_pop, pia;
        int          pops;
        exp_pop = 0;
        case (off)
            4'h0: begin
                exp_pop = !we && q.size() != 0;
                exp_rd  = (q.size() != 0) ? {24'h0, q[0]} : 32'h0000_0100;
            end
            4'h4:    exp_rd = {27'd0, m_pend, m_ferr, rx_busy, rx_full, q.size() == 0};
            4'h8:    exp_rd = {31'd0, m_en};
            default: exp_rd = m_div;
        endcase
        bus(we, BASE | {28'h0, off}, sel, dat, irq_same, rd, pops, pia);
        if (!we) chk({nm, "_rd"}, rd, exp_rd);
        chk({nm, "_pops"}, pops, {31'd0, exp_pop});
        chk({nm, "_pop_in_ack"}, {31'd0, pia}, {31'd0, exp_pop});
        if (we) begin
            case (off)
                4'h4: if (sel[0]) begin
                    if (dat[3]) m_ferr = 0;
                    if (dat[4]) m_pend = 0;
                end
                4'h8: if (sel[0]) m_en = dat[0];
                4'hC: begin
                    mg = m_div;
                    for (int b = 0; b < 4; b++) if (sel[b]) mg[8*b +: 8] = dat[8*b +: 8];
                    m_div = (mg < 32'd4) ? 32'd4 : mg;
                end
                default: ;
            endcase
        end
        if (irq_same) m_pend = 1;
        chk({nm, "_clk_div"}, clk_div, m_div);
        chk({nm, "_irq_o"}, {31'd0, irq_o}, {31'd0, m_pend & m_en});
    endtask

    initial begin
        logic [31:0] rd;
        int          acks;

        cyc = 0; stb = 0; we_i = 0; sel_i = 0; adr_i = 0; dat_i = 0;
        rx_full = 0; rx_busy = 0; rx_irq = 0; rx_frame_err = 0;
        q.delete(); set_fifo();
        model_reset();
        rst_n = 0;
        #12;
        chk("rst_ack", {31'd0, ack}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_pop", {31'd0, rx_pop}, 32'd0);
        chk("rst_clk_div", clk_div, 32'd434);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        @(negedge clk); rst_n = 1;

        tbl[0]  = '{0, 4'hC, 4'hF, 32'h0,         1, 32'd434};
        tbl[1]  = '{0, 4'h8, 4'hF, 32'h0,         1, 32'd0};
        tbl[2]  = '{1, 4'hC, 4'hF, 32'h2,         0, 32'h0};
        tbl[3]  = '{0, 4'hC, 4'hF, 32'h0,         1, 32'd4};
        tbl[4]  = '{1, 4'hC, 4'hF, 32'h1B2,       0, 32'h0};
        tbl[5]  = '{1, 4'hC, 4'h1, 32'h1234,      0, 32'h0};
        tbl[6]  = '{0, 4'hC, 4'hF, 32'h0,         1, 32'h134};
        tbl[7]  = '{1, 4'hC, 4'h3, 32'h0000_0001, 0, 32'h0};
        tbl[8]  = '{0, 4'hC, 4'hF, 32'h0,         1, 32'd4};
        tbl[9]  = '{1, 4'h8, 4'h0, 32'hFFFF_FFFF, 0, 32'h0};
        tbl[10] = '{0, 4'h8, 4'hF, 32'h0,         1, 32'd0};
        tbl[11] = '{1, 4'h8, 4'h1, 32'hFFFF_FFFF, 0, 32'h0};
        tbl[12] = '{0, 4'h8, 4'hF, 32'h0,         1, 32'd1};
        tbl[13] = '{1, 4'h0, 4'hF, 32'h55,        0, 32'h0};
        tbl[14] = '{0, 4'h0, 4'hF, 32'h0,         1, 32'h100};
        tbl[15] = '{1, 4'hC, 4'hF, 32'h1B2,       0, 32'h0};
        for (int i = 0; i < 16; i++) begin
            xact($sformatf("tbl%0d", i), tbl[i].we, tbl[i].off, tbl[i].sel, tbl[i].dat, 0, rd);
            if (tbl[i].chk_rd) chk($sformatf("tbl%0d_const", i), rd, tbl[i].exp);
        end

        // FIFO drain: two data bytes then an empty read
        q.push_back(8'hA5); q.push_back(8'h3C); set_fifo();
        xact("fifo0", 0, 4'h0, 4'hF, 0, 0, rd); chk("fifo0_const", rd, 32'h0000_00A5);
        xact("fifo1", 0, 4'h0, 4'hF, 0, 0, rd); chk("fifo1_const", rd, 32'h0000_003C);
        xact("fifo2", 0, 4'h0, 4'hF, 0, 0, rd); chk("fifo2_const", rd, 32'h0000_0100);

        // irq_o follows irq_pending one cycle later (irq_en is 1 from the table)
        pulse(1, 0);
        chk("irq_lag0", {31'd0, irq_o}, 32'd0);
        @(posedge clk); #1;
        chk("irq_lag1", {31'd0, irq_o}, 32'd1);
        xact("stat_irq", 0, 4'h4, 4'hF, 0, 0, rd); chk("stat_irq_bit", {31'd0, rd[4]}, 32'd1);
        xact("w1c_irq", 1, 4'h4, 4'h1, 32'h10, 0, rd);
        chk("w1c_irq_low", {31'd0, irq_o}, 32'd0);
        xact("set_wins", 1, 4'h4, 4'h1, 32'h10, 1, rd);
        xact("set_wins_rd", 0, 4'h4, 4'hF, 0, 0, rd); chk("set_wins_bit", {31'd0, rd[4]}, 32'd1);

        pulse(0, 1);
        xact("ferr_rd", 0, 4'h4, 4'hF, 0, 0, rd);   chk("ferr_set", {31'd0, rd[3]}, 32'd1);
        xact("ferr_sel0", 1, 4'h4, 4'h0, 32'h08, 0, rd);
        xact("ferr_rd2", 0, 4'h4, 4'hF, 0, 0, rd);  chk("ferr_keep", {31'd0, rd[3]}, 32'd1);
        xact("ferr_clr", 1, 4'h4, 4'h1, 32'h08, 0, rd);
        xact("ferr_rd3", 0, 4'h4, 4'hF, 0, 0, rd);  chk("ferr_clear", {31'd0, rd[3]}, 32'd0);

        // Reset during the RESP cycle of a popping read
        q.push_back(8'h77); set_fifo();
        @(posedge clk); #1;
        cyc = 1; stb = 1; we_i = 0; adr_i = BASE; sel_i = 4'hF;
        @(posedge clk); #1;
        chk("mid_ack", {31'd0, ack}, 32'd1);
        chk("mid_pop", {31'd0, rx_pop}, 32'd1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_ack", {31'd0, ack}, 32'd0);
        chk("mid_rst_pop", {31'd0, rx_pop}, 32'd0);
        cyc = 0; stb = 0;
        @(negedge clk); rst_n = 1;
        model_reset();
        xact("after_rst", 0, 4'h0, 4'hF, 0, 0, rd); chk("after_rst_const", rd, 32'h77);

        // Address just outside the window
        acks = 0;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we_i = 0; adr_i = BASE + 32'h10; sel_i = 4'hF;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk); #1;
            if (ack) acks++;
        end
        cyc = 0; stb = 0;
        chk("miss_no_ack", acks, 32'd0);

        // Random traffic
        for (int it = 0; it < 150; it++) begin
            logic [3:0]  off;
            logic [31:0] dat;
            if ($urandom_range(0, 2) == 0 && q.size() < 8) q.push_back(8'($urandom));
            set_fifo();
            rx_full = 1'($urandom); rx_busy = 1'($urandom);
            if ($urandom_range(0, 3) == 0) pulse(1'($urandom), 1'($urandom));
            off = {2'($urandom_range(0, 3)), 2'b00};
            dat = $urandom_range(0, 1) ? 32'($urandom_range(0, 8)) : $urandom;
            xact($sformatf("rnd%0d", it), 1'($urandom), off, 4'($urandom), dat,
                 ($urandom_range(0, 7) == 0), rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
